regfile_wb_arbiter: RTL

Write-back arbiter sharing the register file's single write port between two requesters: requester 0 (ALU/immediate results) and requester 1 (memory load data). It picks one request per cycle with round-robin fairness, registers the chosen write onto the `regWrite`/`writeAddr`/`writeData` port of the register file, discards writes to register 0, and provides bypass lookups on both read addresses for the one write held in its output stage. It sits between the datapath result sources and the register file.

---
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port,
// with a one-entry output stage and bypass lookup on both read addresses.
module regfile_wb_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]      req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]      req1_data,
  output logic                  req1_ready,
  input  logic                  flush,
  output logic                  regWrite,
  output logic [ADDR_WIDTH-1:0] writeAddr,
  output logic [WIDTH-1:0]      writeData,
  input  logic [ADDR_WIDTH-1:0] readAddr1,
  input  logic [ADDR_WIDTH-1:0] readAddr2,
  output logic                  hit1,
  output logic                  hit2,
  output logic [WIDTH-1:0]      bypassData
);

  typedef enum logic {
    IDLE   = 1'b0,
    STAGED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [WIDTH-1:0]      write_data_q, write_data_d;
  logic                  last_grant_q, last_grant_d;

  logic                  grant0, grant1;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;

  // Contested grant goes to the requester not granted most recently.
  always_comb begin
    grant0 = !flush && req0_valid && (!req1_valid || last_grant_q);
    grant1 = !flush && req1_valid && (!req0_valid || !last_grant_q);
  end

  always_comb begin
    sel_addr = grant1 ? req1_addr : req0_addr;
    sel_data = grant1 ? req1_data : req0_data;
  end

  always_comb begin
    state_d      = IDLE;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    last_grant_d = last_grant_q;
    if (grant0 || grant1) begin
      write_addr_d = sel_addr;
      write_data_d = sel_data;
      last_grant_d = grant1;
      // Writes to register 0 are accepted but never reach the register file.
      state_d      = (sel_addr != '0) ? STAGED : IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      write_addr_q <= '0;
      write_data_q <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    regWrite   = (state_q == STAGED);
    writeAddr  = write_addr_q;
    writeData  = write_data_q;
    bypassData = write_data_q;
    hit1       = regWrite && (write_addr_q == readAddr1) && (readAddr1 != '0);
    hit2       = regWrite && (write_addr_q == readAddr2) && (readAddr2 != '0);
  end

endmodule
